// File: rtl/up_down_counter.sv
// Free-running w-bit binary up/down counter.
// The direction is chosen on every clock edge. The counter wraps modulo 2^w in both directions.
// There is no enable, no load and no terminal-count output.
//
// Ports:
//   clk      rising-edge clock for all state updates
//   reset    asynchronous, active-high clear; q reads 0 while it is asserted
//   control  direction: 1 counts up (+1), 0 counts down (-1)
//   q        current count, driven directly from the state register
module up_down_counter #(
  parameter int unsigned w = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         control,
  output logic [w-1:0] q
);

  localparam logic [w-1:0] One = w'(1);

  logic [w-1:0] count_d;
  logic [w-1:0] count_q;

  // Plain w-bit add/subtract: the carry or borrow drops off, which gives the wrap.
  always_comb begin
    count_d = count_q;
    if (control) begin
      count_d = count_q + One;
    end else begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter.
// Three instances run side by side, at w=4, w=1 and w=8.
// They share one clock, one reset and one control input.
// Each width has its own modulo-arithmetic reference count.
module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       control;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;

  int errors = 0;
  int checks = 0;
  int exp4   = 0;
  int exp1   = 0;
  int exp8   = 0;

  up_down_counter #(.w(4)) u_dut4 (.clk(clk), .reset(reset), .control(control), .q(q4));
  up_down_counter #(.w(1)) u_dut1 (.clk(clk), .reset(reset), .control(control), .q(q1));
  up_down_counter #(.w(8)) u_dut8 (.clk(clk), .reset(reset), .control(control), .q(q8));

  // Period 4. Rising edges fall at t = 3, 7, 11, and so on.
  initial begin
    clk = 1'b0;
    #3;
    forever begin
      clk = 1'b1;
      #2;
      clk = 1'b0;
      #2;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_val(input int cur, input bit up, input int width);
    int m;
    m = 1 << width;
    return up ? (cur + 1) % m : (cur + m - 1) % m;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "/w4"}, int'(q4), exp4);
    check_eq({tag, "/w1"}, int'(q1), exp1);
    check_eq({tag, "/w8"}, int'(q8), exp8);
  endtask

  // Call this while clk is low.
  // It applies one direction, lets the rising edge pass, then updates the model and checks.
  // Control returns at the following falling edge.
  task automatic step(input bit up, input string tag);
    control = up;
    @(posedge clk);
    #1;
    if (reset) begin
      exp4 = 0;
      exp1 = 0;
      exp8 = 0;
    end else begin
      exp4 = next_val(exp4, up, 4);
      exp1 = next_val(exp1, up, 1);
      exp8 = next_val(exp8, up, 8);
    end
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input string tag);
    #1;
    reset = 1'b1;
    exp4 = 0;
    exp1 = 0;
    exp8 = 0;
    #0.5;
    check_all({tag, "_async"});
    @(negedge clk);
    check_all({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    control = 1'b1;
    #1;
    // Reset asserted before the first clock edge.
    reset = 1'b1;
    #1;
    check_all("rst_pre_edge");
    @(posedge clk);
    #1;
    check_all("rst_over_edge");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Count up across the up wrap.
    for (int i = 0; i < 17; i++) step(1'b1, "up_run");
    // Reach 3, then count down across the down wrap.
    step(1'b1, "to3");
    step(1'b1, "to3");
    check_eq("at3", int'(q4), 3);
    for (int i = 0; i < 5; i++) step(1'b0, "down_run");
    check_eq("down_wrap_14", int'(q4), 14);
    // Climb back to 7, then toggle direction every edge.
    for (int i = 0; i < 9; i++) step(1'b1, "to7");
    check_eq("at7", int'(q4), 7);
    for (int i = 0; i < 4; i++) step(i % 2 == 0, "toggle");
    // Reach 9, reset mid-cycle, then release counting down.
    step(1'b1, "to9");
    step(1'b1, "to9");
    check_eq("at9", int'(q4), 9);
    async_reset_pulse("mid9");
    step(1'b0, "rel_down");
    check_eq("rel_down_15", int'(q4), 15);

    // Run w=8 fully around in both directions.
    for (int i = 0; i < 260; i++) step(1'b1, "sweep_up");
    for (int i = 0; i < 260; i++) step(1'b0, "sweep_dn");

    // Random directions, with an occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset_pulse("rand_rst");
      end else begin
        step(1'($urandom_range(0, 1)), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
